// File: rtl/refresh_counter.sv
// refresh_counter: digit-scan timing with mask skipping, inter-digit blanking and digit/frame strobes.
// Define REFRESH_DIM_EN to add a `dim` input that blanks every second frame.
module refresh_counter #(
  parameter int DIV_COUNT    = 100000,
  parameter int NUM_DIGITS   = 2,
  parameter int SEL_W        = 1,
  parameter int BLANK_CYCLES = 1000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  en,
  input  logic [NUM_DIGITS-1:0] digit_mask,
`ifdef REFRESH_DIM_EN
  input  logic                  dim,
`endif
  output logic [SEL_W-1:0]      refreshcounter,
  output logic                  blank,
  output logic                  digit_tick,
  output logic                  frame_start
);
  localparam int PW = $clog2(DIV_COUNT);
  typedef enum logic [1:0] {IDLE, BLANK, SHOW} state_t;
  state_t state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [SEL_W-1:0] nxt, cand, sel_d;
  logic live, run, adv, frame_d, blank_d, dimmed;
  assign live = en && |digit_mask;
  assign run  = live && state_q != IDLE;
  assign adv  = run && presc_q == PW'(DIV_COUNT - 1);
  // Nearest enabled digit after the current one; shortest distance wins.
  always_comb begin
    nxt  = refreshcounter;
    cand = refreshcounter;
    for (int k = NUM_DIGITS; k >= 1; k--) begin
      cand = SEL_W'((int'(refreshcounter) + k) % NUM_DIGITS);
      if (digit_mask[cand]) nxt = cand;
    end
  end
  // Leaving IDLE holds the prescaler, so a paused slot resumes where it stopped.
  assign presc_d = !(|digit_mask) ? '0 : adv ? '0 : run ? presc_q + 1'b1 : presc_q;
  assign sel_d   = adv ? nxt : refreshcounter;
  assign state_d = !live ? IDLE : int'(presc_d) < BLANK_CYCLES ? BLANK : SHOW;
  assign frame_d = adv && nxt <= refreshcounter;
`ifdef REFRESH_DIM_EN
  logic parity_q, parity_d;
  assign parity_d = parity_q ^ frame_d;
  assign dimmed   = dim && parity_d;
  always_ff @(posedge clk or posedge reset)
    if (reset) parity_q <= 1'b0;
    else parity_q <= parity_d;
`else
  assign dimmed = 1'b0;
`endif
  assign blank_d = state_d != SHOW || !digit_mask[sel_d] || dimmed;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= IDLE;
      presc_q        <= '0;
      refreshcounter <= '0;
      blank          <= 1'b1;
      digit_tick     <= 1'b0;
      frame_start    <= 1'b0;
    end else begin
      state_q        <= state_d;
      presc_q        <= presc_d;
      refreshcounter <= sel_d;
      blank          <= blank_d;
      digit_tick     <= adv;
      frame_start    <= frame_d;
    end
  end
endmodule

// File: tb/tb_refresh_counter.sv
// tb_refresh_counter: directed checks of scan timing, masking, pause, mask-off and async reset.
module tb_refresh_counter;
  logic clk = 1'b0, reset = 1'b1, en = 1'b0;
  logic [1:0] digit_mask = 2'b00;
`ifdef REFRESH_DIM_EN
  logic dim = 1'b0;
`endif
  logic refreshcounter, blank, digit_tick, frame_start;
  int n_cmp = 0, n_bad = 0;
  always #5 clk = ~clk;
  refresh_counter #(.DIV_COUNT(8), .NUM_DIGITS(2), .SEL_W(1), .BLANK_CYCLES(2)) dut (
    .clk(clk),
    .reset(reset),
    .en(en),
    .digit_mask(digit_mask),
`ifdef REFRESH_DIM_EN
    .dim(dim),
`endif
    .refreshcounter(refreshcounter),
    .blank(blank),
    .digit_tick(digit_tick),
    .frame_start(frame_start)
  );
  task automatic chk(input string tag, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic outs(input string tag, input int s, input int b, input int t, input int f);
    chk({tag, ".sel"}, int'(refreshcounter), s);
    chk({tag, ".blank"}, int'(blank), b);
    chk({tag, ".tick"}, int'(digit_tick), t);
    chk({tag, ".frame"}, int'(frame_start), f);
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic restart(input logic [1:0] m);
    reset = 1'b1;
    en = 1'b0;
    digit_mask = m;
    step();
    reset = 1'b0;
    #1;
    outs("reset", 0, 1, 0, 0);
    en = 1'b1;
  endtask
  initial begin
    int p, s, t;
    restart(2'b11);
    for (int i = 1; i <= 17; i++) begin
      step();
      p = (i - 1) % 8;
      s = ((i - 1) / 8) % 2;
      t = int'(i > 1 && p == 0);
      outs($sformatf("scan[%0d]", i), s, int'(p < 2), t, int'(t == 1 && s == 0));
    end
    restart(2'b10);
    for (int i = 1; i <= 25; i++) begin
      step();
      p = (i - 1) % 8;
      t = int'(i > 1 && p == 0);
      outs($sformatf("mask10[%0d]", i), int'(i > 8), int'(i <= 8 || p < 2), t, int'(t == 1 && i > 9));
    end
    restart(2'b11);
    repeat (5) step();
    outs("pre_pause", 0, 0, 0, 0);
    en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      outs($sformatf("pause[%0d]", i), 0, 1, 0, 0);
    end
    en = 1'b1;
    step();
    outs("resume", 0, 0, 0, 0);
    repeat (3) step();
    outs("resume_p7", 0, 0, 0, 0);
    step();
    outs("resume_adv", 1, 1, 1, 0);
    repeat (4) step();
    outs("pre_mask0", 1, 0, 0, 0);
    digit_mask = 2'b00;
    for (int i = 0; i < 10; i++) begin
      step();
      outs($sformatf("mask0[%0d]", i), 1, 1, 0, 0);
    end
    digit_mask = 2'b11;
    step();
    outs("restore", 1, 1, 0, 0);
    step();
    outs("restore_p1", 1, 1, 0, 0);
    step();
    outs("restore_p2", 1, 0, 0, 0);
    repeat (5) step();
    outs("restore_p7", 1, 0, 0, 0);
    step();
    outs("restore_adv", 0, 1, 1, 1);
    restart(2'b11);
    repeat (11) step();
    outs("pre_areset", 1, 0, 0, 0);
    reset = 1'b1;
    #1;
    reset = 1'b0;
    #1;
    outs("areset", 0, 1, 0, 0);
    step();
    outs("post_areset", 0, 1, 0, 0);
`ifdef REFRESH_DIM_EN
    dim = 1'b1;
    restart(2'b11);
    for (int i = 1; i <= 48; i++) begin
      step();
      p = (i - 1) % 8;
      s = ((i - 1) / 8) % 2;
      t = int'(i > 1 && p == 0);
      outs($sformatf("dim[%0d]", i), s, int'((i - 1) / 16 == 1 || p < 2), t, int'(t == 1 && s == 0));
    end
    dim = 1'b0;
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
